// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the uart_tx round-robin arbiter and its picker.
// DATA_W default is the common UART byte width used by uart_tx / uart_rx.
package uart_arb_pkg;

  localparam int UART_DATA_W = 8;
  localparam int ARB_NUM_REQ = 4;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } arb_state_e;

  // Grant index width; never narrower than one bit.
  function automatic int gnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ARB_GNT_W = gnt_width(ARB_NUM_REQ);

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// ptr+1 with wrap-around.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = ARB_NUM_REQ,
  parameter int GW = ARB_GNT_W
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic          valid,
  output logic [GW-1:0] idx
);

  logic [GW-1:0] pos_s;

  // Scan farthest-to-nearest so the closest candidate after ptr is kept last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos_s = '0;
    for (int k = N; k >= 1; k--) begin
      pos_s = GW'((int'(ptr) + k) % N);
      if (req[pos_s]) begin
        valid = 1'b1;
        idx   = pos_s;
      end else begin
        valid = valid;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte requesters.
// Optional watchdog enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = ARB_NUM_REQ,
  parameter int DATA_W         = UART_DATA_W,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          tx_start,
  output logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [gnt_width(NUM_REQ)-1:0] grant_id,
  output logic                          timeout_err
);

  localparam int GW = gnt_width(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_e          state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                busy_q, busy_d;

  logic                pick_valid_s;
  logic [GW-1:0]       pick_idx_s;
  logic                gnt_lock_s;
  logic                timeout_hit_s;

  uart_rr_pick #(
    .N  (NUM_REQ),
    .GW (GW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  assign gnt_lock_s = req_lock[gnt_q] & req[gnt_q];

  // Arbitration, locked re-issue and frame completion.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    data_d     = data_q;
    tx_start_d = 1'b0;
    ack_d      = '0;
    done_d     = '0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          gnt_d      = pick_idx_s;
          data_d     = req_data[int'(pick_idx_s)*DATA_W +: DATA_W];
          tx_start_d = 1'b1;
          ack_d      = ONE_HOT0 << pick_idx_s;
          busy_d     = 1'b1;
          state_d    = WAIT_DONE;
        end else begin
          busy_d = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          done_d = ONE_HOT0 << gnt_q;
          if (gnt_lock_s) begin
            data_d     = req_data[int'(gnt_q)*DATA_W +: DATA_W];
            tx_start_d = 1'b1;
            ack_d      = ONE_HOT0 << gnt_q;
          end else begin
            ptr_d   = gnt_q;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (timeout_hit_s) begin
          // Watchdog: drop the frame silently and let the next requester in.
          ptr_d   = gnt_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Registered FSM state and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= GW'(NUM_REQ - 1);
      gnt_q      <= '0;
      data_q     <= '0;
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      data_q     <= data_d;
      tx_start_q <= tx_start_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_err_q, to_err_d;

  assign timeout_hit_s = (state_q == WAIT_DONE) && !tx_done &&
                         (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Count cycles since the latest tx_start; each new byte restarts the count.
  always_comb begin
    cnt_d    = '0;
    to_err_d = timeout_hit_s;
    if (tx_start_d) begin
      cnt_d = '0;
    end else if (state_q == WAIT_DONE) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Watchdog counter and error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      to_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  logic unused_timeout_s;

  assign unused_timeout_s = ^TIMEOUT_CYCLES;
  assign timeout_hit_s    = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  assign tx_start = tx_start_q;
  assign tx_data  = data_q;
  assign req_ack  = ack_q;
  assign req_done = done_q;
  assign busy     = busy_q;
  assign grant_id = gnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level model plus
// directed scenarios and randomized traffic with a behavioural uart_tx.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_lock = '0;
  logic           tx_done = 1'b0;
  logic [N-1:0]   req_ack, req_done;
  logic           tx_start, busy, timeout_err;
  logic [W-1:0]   tx_data;
  logic [1:0]     grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst_n), .req(req), .req_data(req_data), .req_lock(req_lock),
    .req_ack(req_ack), .req_done(req_done), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // main-owned controls
  int         add_cnt[N];
  bit         want_lock[N];
  logic [7:0] byte_tab[N][8];
  int         cancel_gen[N];
  int         spur_req;
  int         resp_mode;   // 0 fixed delay, 1 random delay, 2 never answers
  int         resp_delay;
  int         total, bad;

  // driver / responder / monitor / model state
  int         sent[N];
  int         cancel_seen[N];
  int         rcnt, spur_seen;
  int         ack_q[$];
  logic [7:0] sd_q[$];
  int         start_cnt, coin_cnt, to_cnt;
  int         done_cnt[N];
  bit         m_busy;
  int         m_ptr, m_gnt, m_cyc, m_w;
  logic         e_start, e_busy, e_to;
  logic [N-1:0] e_ack, e_done;
  logic [W-1:0] e_data;
  logic [1:0]   e_gid;

  // requesters: hold req until ack, then present the next byte or drop
  initial begin
    for (int i = 0; i < N; i++) begin sent[i] = 0; cancel_seen[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          req[i] = 1'b0; req_lock[i] = 1'b0;
          sent[i] = add_cnt[i]; cancel_seen[i] = cancel_gen[i];
        end else begin
          if (req_ack[i]) sent[i]++;
          if (cancel_seen[i] != cancel_gen[i]) begin
            req[i] = 1'b0; sent[i] = add_cnt[i]; cancel_seen[i] = cancel_gen[i];
          end else if (sent[i] < add_cnt[i]) begin
            req[i] = 1'b1;
            req_data[i*W +: W] = byte_tab[i][sent[i] % 8];
          end else begin
            req[i] = 1'b0;
          end
          req_lock[i] = want_lock[i];
        end
      end
    end
  end

  // uart_tx stand-in: answers tx_start with a tx_done pulse after a delay
  initial begin
    rcnt = 0; spur_seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_done = 1'b0; rcnt = 0; spur_seen = spur_req;
      end else begin
        tx_done = 1'b0;
        if (tx_start) begin
          if (resp_mode == 0) rcnt = resp_delay;
          else if (resp_mode == 1) rcnt = $urandom_range(14, 2);
          else rcnt = 0;
        end else if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) tx_done = 1'b1;
        end
        if (spur_seen != spur_req) begin spur_seen = spur_req; tx_done = 1'b1; end
      end
    end
  end

  // event log of grants, started bytes and completions
  initial begin
    start_cnt = 0; coin_cnt = 0; to_cnt = 0;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (req_ack[i]) ack_q.push_back(i);
          if (req_done[i]) done_cnt[i]++;
        end
        if (tx_start) begin
          sd_q.push_back(tx_data); start_cnt++;
          if (req_done != '0) coin_cnt++;
        end
        if (timeout_err) to_cnt++;
      end
    end
  end

  function automatic int rr_next(logic [N-1:0] r, int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_issue(int g);
    m_gnt = g; m_busy = 1'b1; m_cyc = 0;
    e_start = 1'b1; e_ack[g] = 1'b1; e_data = req_data[g*W +: W];
    e_gid = 2'(g); e_busy = 1'b1;
  endtask

  // transaction-level reference: expected registered outputs after each edge
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0; m_ptr = N - 1; m_gnt = 0; m_cyc = 0;
        e_start = 1'b0; e_busy = 1'b0; e_to = 1'b0; e_ack = '0; e_done = '0;
        e_data = '0; e_gid = '0;
      end else begin
        e_start = 1'b0; e_ack = '0; e_done = '0; e_to = 1'b0;
        if (!m_busy) begin
          m_w = rr_next(req, m_ptr);
          if (m_w >= 0) model_issue(m_w);
        end else if (tx_done) begin
          e_done[m_gnt] = 1'b1;
          if (req_lock[m_gnt] && req[m_gnt]) model_issue(m_gnt);
          else begin m_ptr = m_gnt; m_busy = 1'b0; e_busy = 1'b0; end
        end else begin
          m_cyc++;
`ifdef UART_ARB_TIMEOUT_EN
          if (m_cyc == TO) begin
            e_to = 1'b1; m_ptr = m_gnt; m_busy = 1'b0; e_busy = 1'b0;
          end
`endif
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // advance one cycle, comparing every DUT output against the model
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      chk("tx_start", tx_start, e_start);
      chk("req_ack", req_ack, e_ack);
      chk("req_done", req_done, e_done);
      chk("busy", busy, e_busy);
      chk("tx_data", tx_data, e_data);
      chk("grant_id", grant_id, e_gid);
      chk("timeout_err", timeout_err, e_to);
    end
    #1;
  endtask

  task automatic queue(int i, int n, logic [7:0] b0, logic [7:0] step, bit lk);
    for (int k = 0; k < n; k++) byte_tab[i][(add_cnt[i] + k) % 8] = b0 + step * 8'(k);
    add_cnt[i] += n;
    want_lock[i] = lk;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
  endtask

  task automatic wait_ack(int i, int lim);
    int n = 0;
    while (!req_ack[i] && n < lim) begin tick(); n++; end
    chk("wait_ack", req_ack[i], 1);
  endtask

  task automatic wait_done(int i, int lim, output int n);
    n = 0;
    while (!req_done[i] && n < lim) begin tick(); n++; end
    chk("wait_done", req_done[i], 1);
  endtask

  task automatic wait_acks(int target, int lim);
    int n = 0;
    while (ack_q.size() < target && n < lim) begin tick(); n++; end
    chk("wait_acks", ack_q.size() >= target, 1);
  endtask

  task automatic wait_idle(int lim);
    int n = 0;
    tick();
    while (busy && n < lim) begin tick(); n++; end
    chk("wait_idle", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

  int b0, s0, c0, d0, st0, n;
  int ord2[5] = '{0, 1, 2, 3, 0};
  int ord3[5] = '{1, 2, 2, 2, 3};
  logic [7:0] dat3[5] = '{8'h44, 8'h11, 8'h22, 8'h33, 8'h55};

  initial begin
    total = 0; bad = 0; spur_req = 0; resp_mode = 0; resp_delay = 20;
    for (int i = 0; i < N; i++) begin
      add_cnt[i] = 0; want_lock[i] = 1'b0; cancel_gen[i] = 0;
      for (int k = 0; k < 8; k++) byte_tab[i][k] = 8'h00;
    end
    do_reset();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ack", req_ack, 0);

    // single request, one-cycle latency, done 20 cycles after the byte starts
    queue(0, 1, 8'hA5, 8'h00, 1'b0);
    tick(); tick();
    chk("t1_start", tx_start, 1);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_ack", req_ack, 4'b0001);
    chk("t1_busy", busy, 1);
    wait_done(0, 40, n);
    chk("t1_done_latency", n, 21);
    chk("t1_done", req_done, 4'b0001);
    chk("t1_busy_end", busy, 0);

    // all four requesting, no locks: rotation 0,1,2,3,0
    do_reset();
    resp_delay = 5;
    b0 = ack_q.size();
    queue(0, 2, 8'h10, 8'h01, 1'b0);
    queue(1, 1, 8'h20, 8'h00, 1'b0);
    queue(2, 1, 8'h30, 8'h00, 1'b0);
    queue(3, 1, 8'h40, 8'h00, 1'b0);
    wait_acks(b0 + 5, 200);
    wait_idle(100);
    chk("t2_count", ack_q.size() - b0, 5);
    if (ack_q.size() - b0 == 5)
      for (int k = 0; k < 5; k++) chk("t2_order", ack_q[b0 + k], ord2[k]);

    // locked three-byte burst from requester 2, then requester 3
    b0 = ack_q.size(); s0 = sd_q.size(); c0 = coin_cnt;
    queue(1, 1, 8'h44, 8'h00, 1'b0);
    queue(2, 3, 8'h11, 8'h11, 1'b1);
    queue(3, 1, 8'h55, 8'h00, 1'b0);
    wait_acks(b0 + 5, 200);
    wait_idle(100);
    chk("t3_count", ack_q.size() - b0, 5);
    if (ack_q.size() - b0 == 5 && sd_q.size() - s0 == 5)
      for (int k = 0; k < 5; k++) begin
        chk("t3_order", ack_q[b0 + k], ord3[k]);
        chk("t3_data", sd_q[s0 + k], dat3[k]);
      end
    chk("t3_back_to_back", coin_cnt - c0, 2);
    want_lock[2] = 1'b0;

    // withdrawn request is never granted; tx_done in IDLE is ignored
    resp_delay = 8;
    b0 = ack_q.size();
    queue(0, 1, 8'h66, 8'h00, 1'b0);
    wait_ack(0, 20);
    queue(1, 1, 8'h77, 8'h00, 1'b0);
    tick(); tick();
    cancel_gen[1]++;
    wait_idle(60);
    tick(); tick(); tick();
    chk("t4_acks", ack_q.size() - b0, 1);
    resp_mode = 2; st0 = start_cnt;
    spur_req++;
    tick(); tick(); tick(); tick();
    chk("t4_no_start", start_cnt - st0, 0);
    chk("t4_idle", busy, 0);

    // reset in the middle of a frame
    queue(0, 1, 8'h88, 8'h00, 1'b0);
    wait_ack(0, 10);
    tick(); tick(); tick();
    d0 = done_cnt[0];
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_start", tx_start, 0);
    chk("t5_ack", req_ack, 0);
    chk("t5_data", tx_data, 0);
    chk("t5_grant", grant_id, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    resp_mode = 0; resp_delay = 6;
    queue(3, 1, 8'h99, 8'h00, 1'b0);
    tick(); tick();
    chk("t5_start_after", tx_start, 1);
    chk("t5_grant_after", grant_id, 3);
    chk("t5_ack_after", req_ack, 4'b1000);
    chk("t5_data_after", tx_data, 8'h99);
    wait_done(3, 20, n);
    chk("t5_no_done_r0", done_cnt[0] - d0, 0);
    wait_idle(20);

`ifdef UART_ARB_TIMEOUT_EN
    // watchdog: no tx_done, error pulse TO cycles after tx_start
    resp_mode = 2;
    d0 = done_cnt[1];
    queue(1, 1, 8'hAB, 8'h00, 1'b0);
    queue(2, 1, 8'hCD, 8'h00, 1'b0);
    wait_ack(1, 10);
    n = 0;
    while (!timeout_err && n < 30) begin tick(); n++; end
    chk("t6_timeout_at", n, TO);
    chk("t6_no_done", done_cnt[1] - d0, 0);
    resp_mode = 0; resp_delay = 4;
    wait_ack(2, 10);
    chk("t6_next_grant", grant_id, 2);
    wait_idle(20);
`endif

    // randomized traffic
    resp_mode = 1;
    repeat (3000) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (add_cnt[i] == sent[i] && $urandom_range(5, 0) == 0)
          queue(i, $urandom_range(3, 1), 8'($urandom), 8'($urandom), 1'($urandom));
        if (req[i] && $urandom_range(49, 0) == 0) cancel_gen[i]++;
      end
      if (!busy && $urandom_range(39, 0) == 0) spur_req++;
    end
    for (int i = 0; i < N; i++) want_lock[i] = 1'b0;
    n = 0;
    while (n < 400 && (busy || req != '0)) begin tick(); n++; end
    chk("drain", busy || (req != '0), 0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
